// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - CPU-side pop/ack and status bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                     rx_pop;
    logic                     err_clr;
    logic [7:0]               rx_data;
    logic                     rx_ack;
    logic                     rx_available;
    logic [$clog2(DEPTH):0]   rx_count;
    logic                     frame_err;
    logic                     overrun;

    modport master (
        output rx_pop, err_clr,
        input  rx_data, rx_ack, rx_available, rx_count, frame_err, overrun
    );

    modport slave (
        input  rx_pop, err_clr,
        output rx_data, rx_ack, rx_available, rx_count, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver with byte FIFO and pop/ack read port
// Optional stop-bit checking is enabled by defining UART_RX_FRAME_CHECK_EN.
module uart_rx_fifo #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            uart_rx,
    uart_rx_fifo_if.slave   bus
);
    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t          state_q, state_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_ack_q, rx_ack_d;
    logic            armed_q, armed_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            stop_sample, wr_en, pop_fire, ferr_set, ovr_set, full;

    always_comb begin
        state_d     = state_q;
        sync1_d     = uart_rx;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        stop_sample = 1'b0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (prev_q && !sync2_q) state_d = S_START;
            end
            S_START: begin
                if (timer_q == TW'(HALF - 1)) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = sync2_q ? S_IDLE : S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (timer_q == TW'(CPB - 1)) begin
                    timer_d   = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_STOP: begin
                if (timer_q == TW'(CPB - 1)) begin
                    timer_d     = '0;
                    stop_sample = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        pop_fire = armed_q && bus.rx_pop && (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        wr_en    = 1'b0;
        ferr_set = 1'b0;
        ovr_set  = 1'b0;
        // A pop completing this cycle frees a slot, so a full FIFO can still accept.
        if (stop_sample) begin
`ifdef UART_RX_FRAME_CHECK_EN
            if (!sync2_q)                ferr_set = 1'b1;
            else if (full && !pop_fire)  ovr_set  = 1'b1;
            else                         wr_en    = 1'b1;
`else
            if (full && !pop_fire)       ovr_set  = 1'b1;
            else                         wr_en    = 1'b1;
`endif
        end

        rx_data_d = rx_data_q;
        rx_ack_d  = 1'b0;
        rd_ptr_d  = rd_ptr_q;
        armed_d   = armed_q;
        if (pop_fire) begin
            rx_data_d = mem_q[rd_ptr_q];
            rx_ack_d  = 1'b1;
            rd_ptr_d  = rd_ptr_q + AW'(1);
            armed_d   = 1'b0;
        end else if (!bus.rx_pop) begin
            armed_d   = 1'b1;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        case ({wr_en, pop_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        frame_err_d = ferr_set ? 1'b1 : (bus.err_clr ? 1'b0 : frame_err_q);
        overrun_d   = ovr_set  ? 1'b1 : (bus.err_clr ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b0;
            timer_q     <= '0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rx_data_q   <= 8'h00;
            rx_ack_q    <= 1'b0;
            armed_q     <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rx_data_q   <= rx_data_d;
            rx_ack_q    <= rx_ack_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage needs no reset; occupancy and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= shift_q;
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_ack       = rx_ack_q;
    assign bus.rx_available = (count_q != '0);
    assign bus.rx_count     = count_q;
    assign bus.frame_err    = frame_err_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    localparam int CLK_HZ = 12000000;
    localparam int BAUD   = 115200;
    localparam int DEPTH  = 8;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_RX_FRAME_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_rx = 1'b1;

    uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_cnt = 0;
    int cyc = 0;
    int last_ack_cyc = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_b;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       stored;
        logic       ferr;
    } vec_t;
    vec_t vecs [5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_ack) begin
            ack_cnt++;
            last_ack_cyc = cyc;
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack: rx_data=%h while no byte expected", bus.rx_data);
            end else begin
                exp_b = sb.pop_front();
                if (bus.rx_data !== exp_b) begin
                    n_bad++;
                    $display("FAIL ack_data: got %h expected %h", bus.rx_data, exp_b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop, input int idle_bits);
        uart_rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            cycles(CPB);
        end
        uart_rx = stop;
        cycles(CPB);
        uart_rx = 1'b1;
        cycles(idle_bits * CPB);
    endtask

    task automatic pop_one();
        int a0;
        int t;
        a0 = ack_cnt;
        bus.rx_pop = 1'b1;
        t = 0;
        while (ack_cnt == a0 && t < 3000) begin
            cycles(1);
            t++;
        end
        cycles(20);
        chk("pop_single_ack", ack_cnt - a0, 1);
        bus.rx_pop = 1'b0;
        cycles(2);
    endtask

    initial begin
        #(10 * 70000);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int a0, t0, lat;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h7E, 1'b0, !FC, FC};
        vecs[4] = '{8'h55, 1'b1, 1'b1, FC};

        bus.rx_pop  = 1'b0;
        bus.err_clr = 1'b0;
        cycles(3);
        rst = 1'b0;
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_ack", bus.rx_ack, 0);
        chk("rst_available", bus.rx_available, 0);
        chk("rst_count", bus.rx_count, 0);
        chk("rst_frame_err", bus.frame_err, 0);
        chk("rst_overrun", bus.overrun, 0);
        cycles(2 * CPB);

        for (int i = 0; i < 5; i++) begin
            send(vecs[i].data, vecs[i].stop, 2);
            if (vecs[i].stored) sb.push_back(vecs[i].data);
            chk("vec_count", bus.rx_count, vecs[i].stored);
            chk("vec_available", bus.rx_available, vecs[i].stored);
            chk("vec_frame_err", bus.frame_err, vecs[i].ferr);
            if (vecs[i].stored) pop_one();
            chk("vec_count_after_pop", bus.rx_count, 0);
        end
        bus.err_clr = 1'b1;
        cycles(1);
        bus.err_clr = 1'b0;
        chk("frame_err_cleared", bus.frame_err, 0);

        for (int i = 1; i <= 9; i++) begin
            send(8'(i), 1'b1, (i == 9) ? 2 : 0);
            if (i <= 8) sb.push_back(8'(i));
        end
        chk("ovr_count", bus.rx_count, DEPTH);
        chk("ovr_flag", bus.overrun, 1);
        chk("ovr_available", bus.rx_available, 1);
        for (int i = 0; i < 8; i++) pop_one();
        chk("ovr_drained", bus.rx_count, 0);
        chk("ovr_sticky", bus.overrun, 1);
        bus.err_clr = 1'b1;
        cycles(1);
        bus.err_clr = 1'b0;
        chk("ovr_cleared", bus.overrun, 0);

        sb.push_back(8'h3C);
        a0 = ack_cnt;
        bus.rx_pop = 1'b1;
        cycles(5);
        chk("wait_no_early_ack", ack_cnt - a0, 0);
        t0 = cyc;
        send(8'h3C, 1'b1, 2);
        cycles(5);
        chk("wait_one_ack", ack_cnt - a0, 1);
        lat = last_ack_cyc - t0;
        chk("wait_latency_window", (lat >= 980 && lat <= 1005), 1);
        bus.rx_pop = 1'b0;
        cycles(2);

        uart_rx = 1'b0;
        cycles(20);
        uart_rx = 1'b1;
        cycles(2 * CPB);
        chk("glitch_count", bus.rx_count, 0);
        chk("glitch_available", bus.rx_available, 0);
        send(8'h55, 1'b1, 2);
        sb.push_back(8'h55);
        chk("post_glitch_count", bus.rx_count, 1);
        pop_one();

        send(8'h11, 1'b1, 0);
        send(8'h22, 1'b1, 2);
        chk("pre_reset_count", bus.rx_count, 2);
        fork
            send(8'hF0, 1'b1, 2);
            begin
                cycles(CPB + 4 * CPB + CPB / 2);
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
                chk("midrst_count", bus.rx_count, 0);
                chk("midrst_available", bus.rx_available, 0);
                chk("midrst_rx_data", bus.rx_data, 0);
                chk("midrst_rx_ack", bus.rx_ack, 0);
                chk("midrst_overrun", bus.overrun, 0);
                chk("midrst_frame_err", bus.frame_err, 0);
            end
        join
        cycles(2 * CPB);
        chk("midrst_no_partial", bus.rx_count, 0);
        send(8'hC3, 1'b1, 2);
        sb.push_back(8'hC3);
        chk("after_rst_count", bus.rx_count, 1);
        pop_one();
        chk("after_rst_empty", bus.rx_count, 0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side UART stage for the softcore SoC: synchronises the `uart_rx` pin, deserialises 8N1 frames and buffers bytes in a small FIFO. It presents them to the CPU memory-mapped read path at the RX data address through a pop/ack handshake. It sits directly upstream of the CPU bus `read_ack`/`data_in` mux and runs on the PLL-derived system clock.

## Interface
- `CLK_HZ`, 12000000, system clock frequency in Hz.
- `BAUD`, 115200, line rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, 104 at defaults); must be ≥ 4.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `clk`  input  1  system clock; one clock domain only.
- `rst`  input  1  reset; synchronous, active-high.
- `uart_rx`  input  1  asynchronous serial line; idle high.
- `rx_pop`  input  1  read request level; held by the bus until `rx_ack`.
- `err_clr`  input  1  one-cycle pulse that clears `frame_err` and `overrun`.
- `rx_data`  output  8  popped byte; registered; valid on and after the `rx_ack` cycle.
- `rx_ack`  output  1  one-cycle pulse completing a pop.
- `rx_available`  output  1  FIFO non-empty.
- `rx_count`  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- `frame_err`  output  1  sticky; a bad stop bit was seen.
- `overrun`  output  1  sticky; a byte was dropped because the FIFO was full.

## Operation
- Two-flop synchroniser on `uart_rx`, then a previous-sample register. Receiver logic uses only the synchronised value.
- RX state machine, with one bit-timer counting 0..CLKS_PER_BIT-1 and a 3-bit bit index:
  - IDLE: on a synchronised falling edge, go to START and clear the timer.
  - START: after CLKS_PER_BIT/2 cycles, sample the line. Low: go to DATA. High: false start, return to IDLE with nothing stored.
  - DATA: every CLKS_PER_BIT cycles, sample one bit into a shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample the stop bit. Handle the byte, then return to IDLE in the same cycle.
- Byte handling at the stop sample:
  - If the FIFO is full (accounting for a pop completing in the same cycle), drop the byte and set `overrun`.
  - Otherwise write the byte at the write pointer.
- Read handshake:
  - A pop is armed once `rx_pop` has been sampled low at least once since the last ack. The arm flag resets to armed.
  - If armed, `rx_pop` is high and the FIFO is non-empty: register the head into `rx_data`, advance the read pointer, assert `rx_ack` for exactly one cycle, then disarm.
  - If the FIFO is empty, the request waits (the CPU stalls) until a byte arrives.
  - Pops are never duplicated while `rx_pop` stays high after the ack.
- Simultaneous write and pop on a full FIFO: both occur and occupancy stays at DEPTH. On an empty FIFO, the pop is served the cycle after the write.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by `rx_count` so that full and empty are distinguishable.
- `err_clr` clears both sticky flags. If a set event occurs in the same cycle, the set wins.

## Timing
- Reset values:
  - `rx_data` = 0x00; `rx_ack`, `rx_available`, `frame_err`, `overrun` = 0; `rx_count` = 0.
  - State = IDLE; synchroniser = 1; previous-sample register = 0.
  - Consequence: a line held low through reset is not taken as a start. A start is accepted only after a high is seen.
- Reset mid-frame or mid-handshake discards the partial byte and all FIFO contents. Any pending pop is dropped without an ack.
- Pin-to-FIFO latency: the byte is written on the stop-sample cycle, about 9.5 bit times after the start edge, plus 2 synchroniser cycles. `rx_available` and `rx_count` update the following cycle.
- Pop latency: `rx_ack` asserts one cycle after the first armed cycle in which `rx_pop` is high and the FIFO is non-empty. `rx_data` changes only on ack cycles.
- Back-to-back frames: receive with no gap, because the stop is handled mid-bit and IDLE is re-entered immediately.

## Configuration
- `UART_RX_FRAME_CHECK_EN` defined:
  - A stop bit sampled low sets `frame_err` and drops the byte.
  - The FIFO is not written and `overrun` is unaffected.
- `UART_RX_FRAME_CHECK_EN` undefined:
  - The stop bit is ignored and the byte is always stored (subject to overrun).
  - `frame_err` is tied to 0.

## Test plan
- Send 0xA5 at 115200 from reset → `rx_available`=1, `rx_count`=1. Hold `rx_pop` → one `rx_ack` pulse, `rx_data`=0xA5, `rx_count`=0. No second ack while `rx_pop` stays high.
- Send 9 bytes 0x01..0x09 with no pops → `rx_count`=8, `overrun`=1. Eight pops return 0x01..0x08. `err_clr` → `overrun`=0.
- Assert `rx_pop` on an empty FIFO, then send 0x3C → `rx_ack` exactly once, about 9.5 bit times later, with `rx_data`=0x3C.
- Pulse the line low for 20 cycles (a glitch shorter than half a bit) → no byte stored, state returns to IDLE. A following valid 0x55 is received correctly.
- Send 0x7E with a stop bit of 0:
  - With `UART_RX_FRAME_CHECK_EN`: `frame_err`=1 and `rx_count`=0.
  - Without it: 0x7E is stored and `frame_err`=0.
- Assert `rst` for one cycle at bit 4 of a frame while 2 bytes are buffered → all outputs return to reset values. The next full frame 0xC3 is received as the only entry.
